// File: rtl/ascii_candidate_gen_pkg.sv
// Shared types and helpers for the ASCII candidate generator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_e        FSM state encoding (IDLE, RUN, DONE)
//   DEF_CHAR_LO/HI default character range ("a".."z")
//   sanitise_char  clamps an out-of-range character to the low bound
package ascii_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] DEF_CHAR_LO = 8'h61;
  localparam logic [7:0] DEF_CHAR_HI = 8'h7A;

  // A seed character outside [lo, hi] is replaced by lo so that every
  // position starts from a legal index.
  function automatic logic [7:0] sanitise_char(input logic [7:0] c,
                                               input logic [7:0] lo,
                                               input logic [7:0] hi);
    if ((c < lo) || (c > hi)) begin
      return lo;
    end
    return c;
  endfunction

endpackage

// File: rtl/ascii_candidate_gen_if.sv
// Candidate stream between the generator and the hash/compare stage.
// Latency: n/a (wires only).
// Backpressure: consumer stalls the stream by holding cand_ready low.
//
// Signals:
//   cand_data   NUM_CHARS bytes, position 0 in the least significant byte
//   cand_valid  candidate available
//   cand_ready  consumer accepts when high together with cand_valid
//   cand_last   current candidate is the final one of the sequence
//   cand_wrap   bit i set if position i wrapped to produce this candidate
interface ascii_candidate_gen_if #(
  parameter int NUM_CHARS = 4
) ();

  logic [8*NUM_CHARS-1:0] cand_data;
  logic                   cand_valid;
  logic                   cand_ready;
  logic                   cand_last;
  logic [NUM_CHARS-1:0]   cand_wrap;

  // Generator side.
  modport master (
    output cand_data,
    output cand_valid,
    output cand_last,
    output cand_wrap,
    input  cand_ready
  );

  // Consumer side.
  modport slave (
    input  cand_data,
    input  cand_valid,
    input  cand_last,
    input  cand_wrap,
    output cand_ready
  );

endinterface

// File: rtl/ascii_candidate_gen_digit.sv
// One character position of the odometer: index register plus modular adder.
// Latency: load/step take effect at the next rising edge; carry_out is combinational.
// Backpressure: holds its value whenever neither load nor step is asserted.
//
// Ports:
//   clock, reset_n  clock and async active-low reset (index resets to 0)
//   load, load_char load a (sanitised) seed character, clear wrap
//   step            advance to the next index computed from add + carry_in
//   add, carry_in   increment for this position (stride for position 0,
//                   carry of the lower position for the others)
//   char_out        current character (CHAR_LO + index)
//   carry_out       the next step would wrap this position
//   wrap            this position wrapped on the last step
module ascii_digit
  import ascii_gen_pkg::*;
#(
  parameter logic [7:0] CHAR_LO = DEF_CHAR_LO,
  parameter logic [7:0] CHAR_HI = DEF_CHAR_HI
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_char,
  input  logic       step,
  input  logic [2:0] add,
  input  logic       carry_in,
  output logic [7:0] char_out,
  output logic       carry_out,
  output logic       wrap
);

  localparam int         RANGE   = int'(CHAR_HI) - int'(CHAR_LO) + 1;
  localparam logic [8:0] RANGE_W = 9'(RANGE);

  logic [7:0] idx;
  logic [8:0] sum;
  logic [7:0] idx_nxt;
  logic [7:0] load_idx;

  // add <= 7 and RANGE >= 8, so the sum is always below 2*RANGE and a
  // single conditional subtraction gives the true modulus.
  assign sum       = {1'b0, idx} + 9'(add) + 9'(carry_in);
  assign carry_out = (sum >= RANGE_W);
  assign idx_nxt   = carry_out ? 8'(sum - RANGE_W) : sum[7:0];

  assign load_idx  = sanitise_char(load_char, CHAR_LO, CHAR_HI) - CHAR_LO;
  assign char_out  = CHAR_LO + idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx  <= 8'd0;
      wrap <= 1'b0;
    end else if (load) begin
      idx  <= load_idx;
      wrap <= 1'b0;
    end else if (step) begin
      idx  <= idx_nxt;
      wrap <= carry_out;
    end
  end

endmodule

// File: rtl/ascii_candidate_gen.sv
// Odometer-order ASCII candidate generator with programmable position-0 stride.
// Latency: start at edge k gives the sanitised seed on cand_data with cand_valid=1 at edge k.
// Backpressure: cand_data/cand_wrap/cand_last hold while cand_valid && !cand_ready.
//
// Ports:
//   clock, reset_n  clock and async active-low reset
//   start           in IDLE, latch seed/stride and begin a run
//   abort           leave RUN without a done pulse (wins over a handshake)
//   seed            starting string, position i in bits [8i+7:8i]
//   stride          position-0 increment per candidate, 0 treated as 1
//   cand            candidate stream (master side)
//   busy            high while running
//   done            one-cycle pulse after the last candidate is accepted
module ascii_candidate_gen
  import ascii_gen_pkg::*;
#(
  parameter int         NUM_CHARS = 4,
  parameter logic [7:0] CHAR_LO   = DEF_CHAR_LO,
  parameter logic [7:0] CHAR_HI   = DEF_CHAR_HI
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*NUM_CHARS-1:0] seed,
  input  logic [2:0]             stride,
  ascii_candidate_gen_if.master  cand,
  output logic                   busy,
  output logic                   done
);

  localparam int RANGE = int'(CHAR_HI) - int'(CHAR_LO) + 1;

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] RUN  = 2'(ST_RUN);
  localparam logic [1:0] DONE = 2'(ST_DONE);

  if (NUM_CHARS < 1) begin : g_bad_num_chars
    $error("ascii_candidate_gen: NUM_CHARS must be at least 1");
  end
  if (RANGE < 8) begin : g_bad_range
    $error("ascii_candidate_gen: CHAR_HI-CHAR_LO+1 must be at least 8");
  end

  logic [1:0]             state;
  logic                   valid_q;
  logic [2:0]             stride_q;
  logic [NUM_CHARS:0]     carry;
  logic [8*NUM_CHARS-1:0] data_w;
  logic [NUM_CHARS-1:0]   wrap_w;
  logic                   in_run;
  logic                   last_w;
  logic                   handshake;
  logic                   load_en;
  logic                   step_en;

  assign in_run    = (state == RUN);
  // Carry out of the top position means the next step would exhaust the
  // sequence, so the candidate on the bus is the final one.
  assign last_w    = in_run && carry[NUM_CHARS];
  assign handshake = valid_q && cand.cand_ready;
  assign load_en   = (state == IDLE) && start && !abort;
  assign step_en   = in_run && !abort && handshake && !carry[NUM_CHARS];

  assign carry[0]  = 1'b0;

  for (genvar i = 0; i < NUM_CHARS; i++) begin : g_pos
    ascii_digit #(
      .CHAR_LO (CHAR_LO),
      .CHAR_HI (CHAR_HI)
    ) u_digit (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (load_en),
      .load_char (seed[8*i +: 8]),
      .step      (step_en),
      .add       ((i == 0) ? stride_q : 3'd0),
      .carry_in  (carry[i]),
      .char_out  (data_w[8*i +: 8]),
      .carry_out (carry[i+1]),
      .wrap      (wrap_w[i])
    );
  end

  assign cand.cand_data  = data_w;
  assign cand.cand_wrap  = wrap_w;
  assign cand.cand_valid = valid_q;
  assign cand.cand_last  = last_w;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      stride_q <= 3'd1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= RUN;
            valid_q  <= 1'b1;
            busy     <= 1'b1;
            stride_q <= (stride == 3'd0) ? 3'd1 : stride;
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
          end else if (handshake && last_w) begin
            state   <= DONE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_candidate_gen.sv
// Directed bench for ascii_candidate_gen: a 2-character and a 3-character
// instance over "a".."z", with hand-computed candidate sequences.
module tb_ascii_candidate_gen;
  import ascii_gen_pkg::*;

  logic clock;
  logic reset_n;

  logic        start_a, abort_a;
  logic [15:0] seed_a;
  logic [2:0]  stride_a;
  logic        busy_a, done_a;

  logic        start_b, abort_b;
  logic [23:0] seed_b;
  logic [2:0]  stride_b;
  logic        busy_b, done_b;

  int n_cmp;
  int n_bad;

  ascii_candidate_gen_if #(.NUM_CHARS(2)) if_a ();
  ascii_candidate_gen_if #(.NUM_CHARS(3)) if_b ();

  ascii_candidate_gen #(.NUM_CHARS(2)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_a),
    .abort   (abort_a),
    .seed    (seed_a),
    .stride  (stride_a),
    .cand    (if_a),
    .busy    (busy_a),
    .done    (done_a)
  );

  ascii_candidate_gen #(.NUM_CHARS(3)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_b),
    .abort   (abort_b),
    .seed    (seed_b),
    .stride  (stride_b),
    .cand    (if_b),
    .busy    (busy_b),
    .done    (done_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {valid, busy, last, done, wrap, data}
  function automatic logic [21:0] obs_a();
    return {if_a.cand_valid, busy_a, if_a.cand_last, done_a, if_a.cand_wrap, if_a.cand_data};
  endfunction

  function automatic logic [30:0] obs_b();
    return {if_b.cand_valid, busy_b, if_b.cand_last, done_b, if_b.cand_wrap, if_b.cand_data};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start instance A from IDLE; returns one cycle after the start edge.
  task automatic run_a(input logic [15:0] s, input logic [2:0] st);
    seed_a   = s;
    stride_a = st;
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
  endtask

  task automatic stop_a();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] ea;
    logic [30:0] eb;
    reset_n = 1'b0;
    #3;
    ea = {4'b0000, 2'b00, 16'h6161};
    eb = {4'b0000, 3'b000, 24'h616161};
    n_cmp++;
    if (obs_a() !== ea) begin
      n_bad++;
      $display("FAIL reset_a got=%h exp=%h", obs_a(), ea);
    end
    n_cmp++;
    if (obs_b() !== eb) begin
      n_bad++;
      $display("FAIL reset_b got=%h exp=%h", obs_b(), eb);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (obs_a() !== ea) begin
      n_bad++;
      $display("FAIL idle_after_reset got=%h exp=%h", obs_a(), ea);
    end
  endtask

  task automatic test_stride1();
    logic [21:0] e;
    if_a.cand_ready = 1'b1;
    run_a(16'h6179, 3'd1);
    e = {4'b1100, 2'b00, 16'h6179};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL stride1_ay got=%h exp=%h", obs_a(), e);
    end
    tick();
    e = {4'b1100, 2'b00, 16'h617A};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL stride1_az got=%h exp=%h", obs_a(), e);
    end
    tick();
    e = {4'b1100, 2'b01, 16'h6261};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL stride1_ba got=%h exp=%h", obs_a(), e);
    end
    stop_a();
  endtask

  task automatic test_stride3_modular();
    logic [21:0] e;
    if_a.cand_ready = 1'b1;
    run_a(16'h6178, 3'd3);
    e = {4'b1100, 2'b00, 16'h6178};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL stride3_ax got=%h exp=%h", obs_a(), e);
    end
    tick();
    e = {4'b1100, 2'b01, 16'h6261};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL stride3_ba got=%h exp=%h", obs_a(), e);
    end
    tick();
    e = {4'b1100, 2'b00, 16'h6264};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL stride3_bd got=%h exp=%h", obs_a(), e);
    end
    stop_a();
  endtask

  task automatic test_last_done();
    logic [21:0] e;
    if_a.cand_ready = 1'b1;
    run_a(16'h7A79, 3'd1);
    e = {4'b1100, 2'b00, 16'h7A79};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL last_zy got=%h exp=%h", obs_a(), e);
    end
    tick();
    e = {4'b1110, 2'b00, 16'h7A7A};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL last_zz got=%h exp=%h", obs_a(), e);
    end
    tick();
    e = {4'b0001, 2'b00, 16'h7A7A};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL done_pulse got=%h exp=%h", obs_a(), e);
    end
    tick();
    e = {4'b0000, 2'b00, 16'h7A7A};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL done_clear got=%h exp=%h", obs_a(), e);
    end
  endtask

  task automatic test_backpressure();
    logic [21:0] e;
    if_a.cand_ready = 1'b1;
    run_a(16'h6179, 3'd1);
    tick();
    if_a.cand_ready = 1'b0;
    e = {4'b1100, 2'b00, 16'h617A};
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (obs_a() !== e) begin
        n_bad++;
        $display("FAIL bp_hold_%0d got=%h exp=%h", c, obs_a(), e);
      end
    end
    if_a.cand_ready = 1'b1;
    tick();
    e = {4'b1100, 2'b01, 16'h6261};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL bp_release got=%h exp=%h", obs_a(), e);
    end
    stop_a();
  endtask

  task automatic test_abort_reset();
    logic [21:0] e;
    if_a.cand_ready = 1'b1;
    run_a(16'h6162, 3'd1);
    tick();
    e = {4'b1100, 2'b00, 16'h6163};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL abort_pre got=%h exp=%h", obs_a(), e);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    e = {4'b0000, 2'b00, 16'h6163};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL abort_hs got=%h exp=%h", obs_a(), e);
    end
    tick();
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL abort_no_done got=%h exp=%h", obs_a(), e);
    end
    run_a(16'h6D61, 3'd2);
    e = {4'b1100, 2'b00, 16'h6D61};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL rerun got=%h exp=%h", obs_a(), e);
    end
    reset_n = 1'b0;
    #2;
    e = {4'b0000, 2'b00, 16'h6161};
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL async_reset got=%h exp=%h", obs_a(), e);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (obs_a() !== e) begin
      n_bad++;
      $display("FAIL post_reset got=%h exp=%h", obs_a(), e);
    end
  endtask

  task automatic test_three_chars();
    logic [30:0] e;
    if_b.cand_ready = 1'b1;
    seed_b   = 24'h613061;
    stride_b = 3'd0;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    e = {4'b1100, 3'b000, 24'h616161};
    n_cmp++;
    if (obs_b() !== e) begin
      n_bad++;
      $display("FAIL n3_sanitise got=%h exp=%h", obs_b(), e);
    end
    tick();
    e = {4'b1100, 3'b000, 24'h616162};
    n_cmp++;
    if (obs_b() !== e) begin
      n_bad++;
      $display("FAIL n3_stride0 got=%h exp=%h", obs_b(), e);
    end
    seed_b   = 24'h7A7A7A;
    stride_b = 3'd5;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    e = {4'b1100, 3'b000, 24'h616163};
    n_cmp++;
    if (obs_b() !== e) begin
      n_bad++;
      $display("FAIL n3_start_ignored got=%h exp=%h", obs_b(), e);
    end
    tick();
    e = {4'b1100, 3'b000, 24'h616164};
    n_cmp++;
    if (obs_b() !== e) begin
      n_bad++;
      $display("FAIL n3_next got=%h exp=%h", obs_b(), e);
    end
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    e = {4'b0000, 3'b000, 24'h616164};
    n_cmp++;
    if (obs_b() !== e) begin
      n_bad++;
      $display("FAIL n3_abort got=%h exp=%h", obs_b(), e);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    start_a  = 1'b0;
    abort_a  = 1'b0;
    seed_a   = 16'h0;
    stride_a = 3'd1;
    start_b  = 1'b0;
    abort_b  = 1'b0;
    seed_b   = 24'h0;
    stride_b = 3'd1;
    if_a.cand_ready = 1'b0;
    if_b.cand_ready = 1'b0;

    test_reset();
    test_stride1();
    test_stride3_modular();
    test_last_done();
    test_backpressure();
    test_abort_reset();
    test_three_chars();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ascii_candidate_gen.md
# ascii_candidate_gen

Multi-position ASCII brute-force candidate generator. It produces every string of `NUM_CHARS` characters in the range `CHAR_LO`..`CHAR_HI`, in odometer order from a loaded seed, one candidate per accepted handshake. Position 0 advances by a programmable stride and each higher position advances by carry. It replaces chains of single-letter counters in the brute-force datapath: the hash/compare stage consumes candidates over a valid/ready interface.

## Interface

Parameters:
- `NUM_CHARS`, default 4: number of character positions; must be ≥ 1.
- `CHAR_LO`, default 8'h61 ("a"): lowest character.
- `CHAR_HI`, default 8'h7A ("z"): highest character. RANGE = CHAR_HI−CHAR_LO+1 must be ≥ 8 (elaboration check).

Ports (clock and reset first):
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse in IDLE: load `seed`/`stride` and begin.
- `abort`  in  1  terminate the current run; no `done`.
- `seed`  in  8*NUM_CHARS  starting string; bits [8i+7:8i] = position i; position 0 is least significant (fastest).
- `stride`  in  3  increment applied to position 0 per advance; 0 is treated as 1.
- `cand_data`  out  8*NUM_CHARS  current candidate, same packing as `seed`.
- `cand_valid`  out  1  candidate available.
- `cand_ready`  in  1  consumer accepts when high with `cand_valid`.
- `cand_last`  out  1  current candidate is the final one of the sequence.
- `cand_wrap`  out  NUM_CHARS  bit i set if position i wrapped to produce the current candidate.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last candidate is accepted.

## Operation

- Index arithmetic: idx = char−CHAR_LO. Seed characters outside CHAR_LO..CHAR_HI load as CHAR_LO (idx 0). Stride is latched at start and cannot change mid-run.
- Position 0: s = idx0+stride. If s ≥ RANGE: idx0 ← s−RANGE (true modular, no reset to CHAR_LO), carry0 = 1. Otherwise idx0 ← s, carry0 = 0.
- Position i>0: if carry(i−1) is set, idx ← idx+1, wrapping RANGE−1→0 with carry(i). Otherwise the position holds.
- Exhaustion: the next step would carry out of position NUM_CHARS−1. `cand_last` is high combinationally with a candidate whose next step would exhaust.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on `start` with `abort` low, load the sanitised seed and clear `cand_wrap`; go to RUN.
  - RUN, on `cand_valid`&`cand_ready`:
    - if `cand_last`, go to DONE;
    - otherwise load the next candidate and its wrap flags.
  - RUN, with `abort` high: go to IDLE. `abort` beats a simultaneous handshake.
  - DONE: `done` = 1 for this one cycle; go to IDLE.
- `start` outside IDLE is ignored. `start`+`abort` together in IDLE: stay IDLE.
- Arithmetic width: 9-bit sums. Internal indices are 8 bits.

## Timing

- Reset values (asynchronous on `reset_n` low):
  - state IDLE;
  - `cand_data` = {NUM_CHARS{CHAR_LO}};
  - `cand_valid`, `cand_last`, `busy`, `done` = 0; `cand_wrap` = 0.
- Latency: `start` sampled at edge k → `cand_valid`=1 and `busy`=1 from edge k. The first candidate equals the sanitised seed.
- Throughput: one candidate per cycle while `cand_ready` is held high.
- Backpressure: while `cand_valid`&!`cand_ready`, `cand_data`, `cand_wrap` and `cand_last` are stable.
- Completion: last handshake at edge k → at edge k, `cand_valid`=0, `busy`=0, `done`=1. At edge k+1, `done`=0.
- Abort at edge k → `cand_valid`=0 and `busy`=0 at edge k. `cand_data` holds its value.
- Reset mid-run: immediate return to the reset values; no `done`.
- All outputs are registered except `cand_last`, which is decoded from registered state.

## Structure

- Package `ascii_gen_pkg`:
  - state enum {IDLE, RUN, DONE};
  - default CHAR_LO/CHAR_HI localparams;
  - function `sanitise_char`.
- Sub-module `ascii_digit`: one position. It holds the idx register and has inputs add amount, carry_in and load. Outputs are char, carry_out and wrap. Instantiate it NUM_CHARS times via generate, with the carry chain rippling from position 0 upward.
- Top level: FSM, handshake, stride latch, `cand_last` decode.

## Test plan

Strings are written high→low position, NUM_CHARS=2 unless stated.
- Seed "ay", stride 1, ready=1 → "ay","az","ba" on consecutive cycles; `cand_wrap`=2'b01 with "ba" only.
- Seed "ax", stride 3 → "ax","ba","bd"; "ba" shows position 0 wrapped modulo 26 (x+3 → a).
- Seed "zy", stride 1 → "zy","zz" (`cand_last`=1 on "zz"); `done` pulses for one cycle after the "zz" handshake; exactly 2 candidates total.
- Backpressure: hold `cand_ready` low 3 cycles on "az" → data, valid and wrap are stable; release → "ba" next cycle.
- `abort` on the same cycle as a handshake, mid-run → `cand_valid`=0 and no `done`. Then pulse `reset_n` low while running → all outputs go to reset values without waiting for a clock edge.
- NUM_CHARS=3, seed "a0a" ("0" out of range), stride 0 → first candidate "aaa", then "aab" (stride treated as 1). `start` pulsed during RUN is ignored.
